// File: rtl/microc_stk_if.sv
// Core-side bus: instruction fetch from an external combinational ROM plus the
// valid/ready output port.
interface microc_stk_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 10
);
    logic [PC_W-1:0]   pc;
    logic [15:0]       instr;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output pc, out_data, out_valid, input instr, out_ready);
    modport slave  (input pc, out_data, out_valid, output instr, out_ready);
endinterface

// File: rtl/microc_stk.sv
// Single-cycle microcontroller core: 16x register file, 8-op ALU, zero flag,
// hardware return-address stack and RUN/WAIT_OUT/HALT/FAULT control FSM.
module microc_stk #(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4,
    localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    microc_stk_if.master    bus,
    output logic            z,
    output logic            halted,
    output logic            fault,
    output logic [SP_W-1:0] sp_level
);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int STK_N = 1 << IDX_W;

    typedef enum logic [1:0] {RUN, WAIT_OUT, HALT, FAULT} state_t;

    state_t                       r_state;
    logic [PC_W-1:0]              r_pc;
    logic [15:0][DATA_W-1:0]      r_regs;
    logic                         r_z;
    logic [SP_W-1:0]              r_sp;
    logic [PC_W-1:0]              r_stk [0:STK_N-1];
    logic [DATA_W-1:0]            r_out_data;
    logic                         r_out_valid;
    logic                         r_halted;
    logic                         r_fault;

    logic [3:0]        w_rd, w_rs1, w_rs2;
    logic [DATA_W-1:0] w_a, w_b, w_res, w_imm;
    logic [PC_W-1:0]   w_tgt, w_pc_inc;
    logic [IDX_W-1:0]  w_push_idx, w_pop_idx;

    assign w_rd       = bus.instr[3:0];
    assign w_rs2      = bus.instr[7:4];
    assign w_rs1      = bus.instr[11:8];
    assign w_imm      = DATA_W'(bus.instr[11:4]);
    assign w_tgt      = PC_W'(bus.instr[11:0]);
    assign w_pc_inc   = r_pc + 1'b1;
    assign w_push_idx = IDX_W'(r_sp);
    assign w_pop_idx  = IDX_W'(r_sp - 1'b1);
    // R0 is hardwired to zero on the read side; writes to it are dropped below
    assign w_a        = (w_rs1 == 4'd0) ? '0 : r_regs[w_rs1];
    assign w_b        = (w_rs2 == 4'd0) ? '0 : r_regs[w_rs2];

    always_comb begin
        w_res = '0;
        case (bus.instr[14:12])
            3'b000: w_res = w_a;
            3'b001: w_res = ~w_a;
            3'b010: w_res = w_a + w_b;
            3'b011: w_res = w_a - w_b;
            3'b100: w_res = w_a & w_b;
            3'b101: w_res = w_a | w_b;
            3'b110: w_res = -w_a;
            default: w_res = -w_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_pc        <= '0;
            r_regs      <= '0;
            r_z         <= 1'b0;
            r_sp        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (!bus.instr[15]) begin
                        if (w_rd != 4'd0) r_regs[w_rd] <= w_res;
                        r_z  <= (w_res == '0);
                        r_pc <= w_pc_inc;
                    end else begin
                        case (bus.instr[14:12])
                            3'b000: begin
                                if (w_rd != 4'd0) r_regs[w_rd] <= w_imm;
                                r_pc <= w_pc_inc;
                            end
                            3'b001: r_pc <= w_tgt;
                            3'b010: r_pc <= r_z ? w_tgt : w_pc_inc;
                            3'b011: r_pc <= r_z ? w_pc_inc : w_tgt;
                            3'b100: begin
                                // a faulting call/return leaves pc and stack untouched
                                if (r_sp == SP_W'(STACK_DEPTH)) begin
                                    r_state <= FAULT;
                                    r_fault <= 1'b1;
                                end else begin
                                    r_stk[w_push_idx] <= w_pc_inc;
                                    r_sp <= r_sp + 1'b1;
                                    r_pc <= w_tgt;
                                end
                            end
                            3'b101: begin
                                if (r_sp == '0) begin
                                    r_state <= FAULT;
                                    r_fault <= 1'b1;
                                end else begin
                                    r_pc <= r_stk[w_pop_idx];
                                    r_sp <= r_sp - 1'b1;
                                end
                            end
                            3'b110: begin
                                r_out_data  <= w_a;
                                r_out_valid <= 1'b1;
                                r_pc        <= w_pc_inc;
                                r_state     <= WAIT_OUT;
                            end
                            default: begin
                                r_state  <= HALT;
                                r_halted <= 1'b1;
                            end
                        endcase
                    end
                end
                WAIT_OUT: begin
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc        = r_pc;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign z             = r_z;
    assign halted        = r_halted;
    assign fault         = r_fault;
    assign sp_level      = r_sp;
endmodule

// File: tb/tb_microc_stk.sv
// Directed bench for microc_stk: small programs in a combinational ROM model,
// outputs sampled 1ns after each rising edge.
module tb_microc_stk;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       z, halted, fault;
    logic [2:0] sp_level;
    logic [15:0] rom [0:1023];
    int n_chk = 0;
    int n_fail = 0;

    microc_stk_if #(.DATA_W(8), .PC_W(10)) bus ();
    assign bus.instr = rom[bus.pc];

    microc_stk #(.DATA_W(8), .PC_W(10), .STACK_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .z(z), .halted(halted), .fault(fault), .sp_level(sp_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 16'hF000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, 32'(bus.pc), 0);
        chk({tag, "_ov"}, 32'(bus.out_valid), 0);
        chk({tag, "_od"}, 32'(bus.out_data), 0);
        chk({tag, "_z"}, 32'(z), 0);
        chk({tag, "_hlt"}, 32'(halted), 0);
        chk({tag, "_flt"}, 32'(fault), 0);
        chk({tag, "_sp"}, 32'(sp_level), 0);
    endtask

    initial begin
        bus.out_ready = 1'b1;

        // 1: LI/LI/ADD/OUT with ready high
        clr_rom();
        rom[0] = 16'h8051; rom[1] = 16'h8032; rom[2] = 16'h2123; rom[3] = 16'hE300;
        do_reset();
        chk_reset("t1_rst");
        repeat (4) tick();
        chk("t1_ov", 32'(bus.out_valid), 1);
        chk("t1_od", 32'(bus.out_data), 8);
        chk("t1_z", 32'(z), 0);
        chk("t1_pc", 32'(bus.pc), 4);
        tick();
        chk("t1_ov_drop", 32'(bus.out_valid), 0);
        chk("t1_od_hold", 32'(bus.out_data), 8);
        tick();
        chk("t1_hlt", 32'(halted), 1);
        chk("t1_hlt_pc", 32'(bus.pc), 4);

        // 2: countdown loop, three SUBs before falling through
        clr_rom();
        rom[0] = 16'h8031; rom[1] = 16'h8012; rom[2] = 16'h3121; rom[3] = 16'hB002;
        do_reset();
        repeat (6) tick();
        chk("t2_z_mid", 32'(z), 0);
        chk("t2_pc_mid", 32'(bus.pc), 2);
        repeat (2) tick();
        chk("t2_z", 32'(z), 1);
        chk("t2_not_hlt", 32'(halted), 0);
        tick();
        chk("t2_hlt", 32'(halted), 1);
        chk("t2_pc", 32'(bus.pc), 4);

        // 3a: five nested calls overflow a 4-deep stack
        clr_rom();
        rom[0] = 16'hC00A; rom[10] = 16'hC014; rom[20] = 16'hC01E;
        rom[30] = 16'hC028; rom[40] = 16'hC032;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("t3_sp%0d", i), 32'(sp_level), 32'(i));
        end
        chk("t3_pc4", 32'(bus.pc), 40);
        tick();
        chk("t3_flt", 32'(fault), 1);
        chk("t3_flt_pc", 32'(bus.pc), 40);
        chk("t3_flt_sp", 32'(sp_level), 4);
        tick();
        chk("t3_frozen_pc", 32'(bus.pc), 40);

        // 3b: four calls then four returns
        rom[40] = 16'hD000; rom[31] = 16'hD000; rom[21] = 16'hD000;
        rom[11] = 16'hD000; rom[1] = 16'hF000;
        do_reset();
        chk("t3b_rst_flt", 32'(fault), 0);
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t3b_ret_pc%0d", i), 32'(bus.pc), 32'(31 - 10 * i));
            chk($sformatf("t3b_ret_sp%0d", i), 32'(sp_level), 32'(3 - i));
        end
        tick();
        chk("t3b_hlt", 32'(halted), 1);
        chk("t3b_flt", 32'(fault), 0);

        // 4: return with empty stack
        clr_rom();
        rom[0] = 16'hD000;
        do_reset();
        tick();
        chk("t4_flt", 32'(fault), 1);
        chk("t4_pc", 32'(bus.pc), 0);
        chk("t4_sp", 32'(sp_level), 0);
        do_reset();
        chk("t4_rst_flt", 32'(fault), 0);
        chk("t4_rst_pc", 32'(bus.pc), 0);

        // 5: output stalled by consumer, then reset during the wait
        clr_rom();
        rom[0] = 16'h85A1; rom[1] = 16'hE100;
        bus.out_ready = 1'b0;
        do_reset();
        repeat (2) tick();
        chk("t5_ov", 32'(bus.out_valid), 1);
        chk("t5_od", 32'(bus.out_data), 32'h5A);
        repeat (10) tick();
        chk("t5_ov_hold", 32'(bus.out_valid), 1);
        chk("t5_pc_hold", 32'(bus.pc), 2);
        do_reset();
        chk("t5_rst_ov", 32'(bus.out_valid), 0);
        chk("t5_rst_od", 32'(bus.out_data), 0);
        bus.out_ready = 1'b1;

        // 6: pc wrap at top of address space and R0 hardwired to zero
        clr_rom();
        rom[0] = 16'hB3FE; rom[1022] = 16'h3000; rom[1023] = 16'h8AA1;
        rom[1] = 16'h2110; rom[2] = 16'hE000; rom[3] = 16'hE100;
        do_reset();
        tick();
        chk("t6_pc_3fe", 32'(bus.pc), 32'h3FE);
        tick();
        chk("t6_z1", 32'(z), 1);
        chk("t6_pc_3ff", 32'(bus.pc), 32'h3FF);
        tick();
        chk("t6_wrap", 32'(bus.pc), 0);
        repeat (2) tick();
        chk("t6_z0", 32'(z), 0);
        tick();
        chk("t6_r0_ov", 32'(bus.out_valid), 1);
        chk("t6_r0", 32'(bus.out_data), 0);
        repeat (2) tick();
        chk("t6_r1", 32'(bus.out_data), 32'hAA);
        repeat (2) tick();
        chk("t6_hlt", 32'(halted), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
